rx_d2c_test_responder: RTL
==========================

Name: rx_d2c_test_responder

Overview:
Parametrised RX-side responder for receiver-initiated data-to-clock tests. It handles both the point test and the multi-step sweep test selected by the LTSM. It answers partner sideband requests, drives the local pattern comparator, and accumulates per-lane error results that are returned with each COUNT_DONE response. It adds two capabilities to the single-shot point responder: a per-wait-state timeout with an error exit, and a bounded sweep step counter.

Parameters:
SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes
NUM_LANES, 16, number of mainband lanes whose error flags are accumulated
STEP_W, 5, width of sweep step counter; max steps = 2^STEP_W - 1
TIMEOUT_W, 16, width of wait-state timeout counter
TIMEOUT_CYCLES, 16'hFFFF, cycles spent in any WAIT_* state before timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_test_en  in  1  LTSM enable; low at any time returns FSM to IDLE
i_sweep_mode  in  1  0: point test (one step), 1: sweep (multiple steps); sampled in IDLE only
i_datavref_or_valvref  in  1  0: data lanes, 1: valid lane
i_rx_msg_valid  in  1  decoded sideband message valid strobe
i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message
i_SB_Busy  in  1  sideband transmitter busy
i_falling_edge_busy  in  1  one-cycle pulse: sideband consumed the message
i_tx_valid  in  1  TX-side responder currently owns the sideband bus
i_lane_errors  in  NUM_LANES  per-lane comparator error flags, valid while comparing
o_encoded_SB_msg_rx  out  SB_MSG_WIDTH  response code to sideband
o_valid_rx  out  1  response valid to wrapper
o_lane_result  out  NUM_LANES  sticky lane errors snapshot sent with COUNT_DONE_RESP
o_mainband_pattern_comparator_cw  out  2  00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 unused
o_comparison_valid_en  out  1  valid-lane comparison enable (valvref mode)
o_step_count  out  STEP_W  completed steps
o_done  out  1  test completed normally
o_timeout  out  1  test aborted by timeout or protocol overflow

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters, accumulator and pending flag 0.
- Message codes: 1 START_REQ, 2 START_RESP, 3 CLR_REQ, 4 CLR_RESP, 5 COUNT_DONE_REQ, 6 COUNT_DONE_RESP, 7 END_REQ, 8 END_RESP.
- States: IDLE, WAIT_START, SEND_START, WAIT_CLR, SEND_CLR, WAIT_CNT, SEND_CNT, WAIT_NEXT, SEND_END, DONE, ERROR.
- IDLE -> WAIT_START when i_test_en = 1. In IDLE, o_done = o_timeout = 0, the cw is 00, enables are 0, and o_step_count and o_lane_result are cleared.
- A WAIT_X state advances to its SEND_X state on i_rx_msg_valid with the matching code. Non-matching messages are ignored.
- WAIT_NEXT:
  - END_REQ -> SEND_END.
  - CLR_REQ -> SEND_CLR, only if i_sweep_mode = 1 and o_step_count < 2^STEP_W-1.
  - CLR_REQ at max step count -> ERROR.
  - CLR_REQ in point mode is ignored.
- Every SEND_X state:
  - o_encoded_SB_msg_rx is registered on the entry transition.
  - o_valid_rx sets on the cycle after entry if i_SB_Busy = 0 and i_tx_valid = 0.
  - Otherwise a pending flag is set, and o_valid_rx sets on the first cycle with i_tx_valid = 0.
  - o_valid_rx clears on i_falling_edge_busy; the clear wins over a simultaneous set.
  - The FSM leaves the SEND state on the cycle after o_valid_rx falls: SEND_START -> WAIT_CLR, SEND_CLR -> WAIT_CNT, SEND_CNT -> WAIT_NEXT, SEND_END -> DONE.
- Comparator control:
  - On entry to SEND_CLR: datavref sets cw = 01 and clears the lane accumulator; valvref sets o_comparison_valid_en = 1.
  - On SEND_CLR -> WAIT_CNT with datavref: cw = 10.
  - While cw = 10 or o_comparison_valid_en = 1: accumulator |= i_lane_errors.
  - On entry to SEND_CNT: cw = 00, o_comparison_valid_en = 0, o_lane_result = accumulator including that cycle's flags, o_step_count += 1.
- Timeout:
  - The counter runs only in WAIT_* states and resets on every state change.
  - When it equals TIMEOUT_CYCLES-1 without a matching message, the FSM goes to ERROR.
  - ERROR: o_timeout = 1, cw = 00, enables 0, o_valid_rx = 0.
  - A matching message on the same cycle as expiry wins; the normal transition is taken.
- DONE: o_done = 1. DONE and ERROR hold until i_test_en = 0, then go to IDLE.
- i_test_en low in any state: next cycle IDLE, o_valid_rx = 0, pending flag cleared. A transfer already accepted by the sideband is not recalled.
- Latency: request strobe to o_valid_rx = 2 cycles when the bus is free.

Test Plan:
1. Point datavref, bus free: START/CLR/COUNT_DONE/END requests, each acknowledged via i_falling_edge_busy -> responses 2,4,6,8. cw sequence 01,10,00. o_step_count = 1. o_done = 1.
2. Sweep, 3 steps: lane 3 errors in step 2 only -> o_lane_result = 0x0008 after step 2 and 0x0000 after steps 1 and 3. o_step_count = 3. END -> o_done = 1.
3. i_tx_valid high for 5 cycles at START_REQ -> o_valid_rx rises on the first cycle after i_tx_valid falls. Response code = 2, unchanged throughout.
4. No request in WAIT_CNT for TIMEOUT_CYCLES (overridden to 8) -> ERROR. o_timeout = 1, cw = 00. Drop i_test_en -> IDLE, o_timeout = 0.
5. Valvref sweep with STEP_W = 2: 4th CLR_REQ -> ERROR. o_comparison_valid_en pulses only between CLR_RESP entry and COUNT_DONE_RESP entry.
6. Deassert i_test_en while o_valid_rx = 1 in SEND_CLR -> next cycle IDLE, o_valid_rx = 0, all outputs at reset values.

Source files
------------

// File: rtl/rx_d2c_test_responder.sv
// RX-side responder for receiver-initiated D2C point and sweep tests: answers partner
// sideband requests, steers the local comparator and returns per-lane error results.
module rx_d2c_test_responder #(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned STEP_W         = 5,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_test_en,
    input  logic                    i_sweep_mode,
    input  logic                    i_datavref_or_valvref,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_SB_Busy,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    input  logic [NUM_LANES-1:0]    i_lane_errors,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic [NUM_LANES-1:0]    o_lane_result,
    output logic [1:0]              o_mainband_pattern_comparator_cw,
    output logic                    o_comparison_valid_en,
    output logic [STEP_W-1:0]       o_step_count,
    output logic                    o_done,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] START_REQ  = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] START_RESP = SB_MSG_WIDTH'(2);
    localparam logic [SB_MSG_WIDTH-1:0] CLR_REQ    = SB_MSG_WIDTH'(3);
    localparam logic [SB_MSG_WIDTH-1:0] CLR_RESP   = SB_MSG_WIDTH'(4);
    localparam logic [SB_MSG_WIDTH-1:0] CNT_REQ    = SB_MSG_WIDTH'(5);
    localparam logic [SB_MSG_WIDTH-1:0] CNT_RESP   = SB_MSG_WIDTH'(6);
    localparam logic [SB_MSG_WIDTH-1:0] END_REQ    = SB_MSG_WIDTH'(7);
    localparam logic [SB_MSG_WIDTH-1:0] END_RESP   = SB_MSG_WIDTH'(8);

    localparam logic [1:0] CW_IDLE = 2'b00;
    localparam logic [1:0] CW_CLR  = 2'b01;
    localparam logic [1:0] CW_LFSR = 2'b10;

    localparam logic [STEP_W-1:0]    STEP_MAX = {STEP_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_START, SEND_START, WAIT_CLR, SEND_CLR, WAIT_CNT,
        SEND_CNT, WAIT_NEXT, SEND_END, DONE, ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [TIMEOUT_W-1:0]    tcnt_q, tcnt_d;
    logic [NUM_LANES-1:0]    acc_q, acc_d;
    logic                    pending_q, pending_d;
    logic                    launched_q, launched_d;
    logic                    acked_q, acked_d;
    logic                    sweep_q, sweep_d;
    logic [SB_MSG_WIDTH-1:0] msg_d;
    logic                    valid_d;
    logic [NUM_LANES-1:0]    result_d;
    logic [1:0]              cw_d;
    logic                    cmp_en_d;
    logic [STEP_W-1:0]       step_d;
    logic                    done_d;
    logic                    timeout_d;
    logic                    expired;
    logic                    is_send;

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        acc_d      = acc_q;
        pending_d  = pending_q;
        launched_d = launched_q;
        acked_d    = acked_q;
        sweep_d    = sweep_q;
        msg_d      = o_encoded_SB_msg_rx;
        valid_d    = o_valid_rx;
        result_d   = o_lane_result;
        cw_d       = o_mainband_pattern_comparator_cw;
        cmp_en_d   = o_comparison_valid_en;
        step_d     = o_step_count;
        done_d     = o_done;
        timeout_d  = o_timeout;
        expired    = (tcnt_q == TO_LAST);
        is_send    = (state_q == SEND_START) || (state_q == SEND_CLR) ||
                     (state_q == SEND_CNT)   || (state_q == SEND_END);

        if (o_mainband_pattern_comparator_cw == CW_LFSR || o_comparison_valid_en)
            acc_d = acc_q | i_lane_errors;

        // Response handshake: a falling-busy pulse clears valid and beats any set.
        if (is_send) begin
            if (i_falling_edge_busy && o_valid_rx) begin
                valid_d = 1'b0;
                acked_d = 1'b1;
            end else if (!launched_q && !acked_q && !i_falling_edge_busy) begin
                if (!pending_q) begin
                    if (!i_SB_Busy && !i_tx_valid) begin
                        valid_d    = 1'b1;
                        launched_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end else if (!i_tx_valid) begin
                    valid_d    = 1'b1;
                    launched_d = 1'b1;
                    pending_d  = 1'b0;
                end
            end
        end

        if (!i_test_en || state_q == IDLE) begin
            state_d    = i_test_en ? WAIT_START : IDLE;
            sweep_d    = i_sweep_mode;
            acc_d      = '0;
            msg_d      = '0;
            valid_d    = 1'b0;
            result_d   = '0;
            cw_d       = CW_IDLE;
            cmp_en_d   = 1'b0;
            step_d     = '0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            pending_d  = 1'b0;
            launched_d = 1'b0;
            acked_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_START: begin
                    if (i_rx_msg_valid && i_decoded_SB_msg == START_REQ) begin
                        state_d = SEND_START;
                        msg_d   = START_RESP;
                    end else if (expired) state_d = ERROR;
                    else tcnt_d = tcnt_q + TIMEOUT_W'(1);
                end
                WAIT_CLR: begin
                    if (i_rx_msg_valid && i_decoded_SB_msg == CLR_REQ) begin
                        state_d = SEND_CLR;
                        msg_d   = CLR_RESP;
                    end else if (expired) state_d = ERROR;
                    else tcnt_d = tcnt_q + TIMEOUT_W'(1);
                end
                WAIT_CNT: begin
                    if (i_rx_msg_valid && i_decoded_SB_msg == CNT_REQ) begin
                        state_d  = SEND_CNT;
                        msg_d    = CNT_RESP;
                        cw_d     = CW_IDLE;
                        cmp_en_d = 1'b0;
                        result_d = acc_d;
                        step_d   = o_step_count + STEP_W'(1);
                    end else if (expired) state_d = ERROR;
                    else tcnt_d = tcnt_q + TIMEOUT_W'(1);
                end
                WAIT_NEXT: begin
                    if (i_rx_msg_valid && i_decoded_SB_msg == END_REQ) begin
                        state_d = SEND_END;
                        msg_d   = END_RESP;
                    end else if (i_rx_msg_valid && i_decoded_SB_msg == CLR_REQ && sweep_q) begin
                        if (o_step_count == STEP_MAX) begin
                            state_d = ERROR;
                        end else begin
                            state_d = SEND_CLR;
                            msg_d   = CLR_RESP;
                        end
                    end else if (expired) state_d = ERROR;
                    else tcnt_d = tcnt_q + TIMEOUT_W'(1);
                end
                SEND_START: if (acked_q) state_d = WAIT_CLR;
                SEND_CLR: begin
                    if (acked_q) begin
                        state_d = WAIT_CNT;
                        if (!i_datavref_or_valvref) cw_d = CW_LFSR;
                    end
                end
                SEND_CNT: if (acked_q) state_d = WAIT_NEXT;
                SEND_END: begin
                    if (acked_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE, ERROR: state_d = state_q;
                default: state_d = IDLE;
            endcase

            // Comparator set-up on every entry into SEND_CLR.
            if (state_d == SEND_CLR && state_q != SEND_CLR) begin
                if (!i_datavref_or_valvref) begin
                    cw_d  = CW_CLR;
                    acc_d = '0;
                end else begin
                    cmp_en_d = 1'b1;
                end
            end

            if (state_d == ERROR && state_q != ERROR) begin
                timeout_d = 1'b1;
                cw_d      = CW_IDLE;
                cmp_en_d  = 1'b0;
                valid_d   = 1'b0;
            end
        end

        if (state_d != state_q) begin
            tcnt_d     = '0;
            pending_d  = 1'b0;
            launched_d = 1'b0;
            acked_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q                          <= IDLE;
            tcnt_q                           <= '0;
            acc_q                            <= '0;
            pending_q                        <= 1'b0;
            launched_q                       <= 1'b0;
            acked_q                          <= 1'b0;
            sweep_q                          <= 1'b0;
            o_encoded_SB_msg_rx              <= '0;
            o_valid_rx                       <= 1'b0;
            o_lane_result                    <= '0;
            o_mainband_pattern_comparator_cw <= CW_IDLE;
            o_comparison_valid_en            <= 1'b0;
            o_step_count                     <= '0;
            o_done                           <= 1'b0;
            o_timeout                        <= 1'b0;
        end else begin
            state_q                          <= state_d;
            tcnt_q                           <= tcnt_d;
            acc_q                            <= acc_d;
            pending_q                        <= pending_d;
            launched_q                       <= launched_d;
            acked_q                          <= acked_d;
            sweep_q                          <= sweep_d;
            o_encoded_SB_msg_rx              <= msg_d;
            o_valid_rx                       <= valid_d;
            o_lane_result                    <= result_d;
            o_mainband_pattern_comparator_cw <= cw_d;
            o_comparison_valid_en            <= cmp_en_d;
            o_step_count                     <= step_d;
            o_done                           <= done_d;
            o_timeout                        <= timeout_d;
        end
    end

endmodule
